// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the ccff chain loader.
// State encoding and CRC-16-CCITT parameters.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/ccff_chain_loader_crc16.sv
// Bit-serial CRC-16-CCITT, MSB first, one bit per enabled cycle.
// Used by ccff_chain_loader only when CCFF_CRC_CHECK_EN is defined.
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  // feedback bit of the LFSR
  always_comb fb = din ^ crc[15];

  // CRC register: clear restarts from the init value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC16_INIT;
    end else if (clr) begin
      crc <= CRC16_INIT;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams a byte bitstream MSB first into a ccff configuration chain.
// Define CCFF_CRC_CHECK_EN to append a CRC-16 check of the loaded bits.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64
) (
  input  logic       prog_clk,
  input  logic       prog_reset,
  input  logic       start,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       ccff_head,
  output logic       ccff_shift_en,
  output logic       cfg_done,
  output logic       cfg_error,
  output logic       busy
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN - 1);

  state_t        state_q, state_d;
  logic [7:0]    sbuf_q;
  logic [3:0]    cnt_q;
  logic [CW-1:0] bit_q;
  logic          go, shift, last, accept;

`ifdef CCFF_CRC_CHECK_EN
  logic [15:0] crc;
  logic [7:0]  hi_q;
  logic        hi_vld_q;
`endif

  // handshake, shift qualifiers and status outputs
  always_comb begin
    go     = start && (state_q == ST_IDLE ||
                       state_q == ST_DONE ||
                       state_q == ST_ERROR);
    shift  = (state_q == ST_LOAD) && (cnt_q != 4'd0);
    last   = shift && (bit_q == LAST);
    s_ready = (state_q == ST_CHECK) ||
              ((state_q == ST_LOAD) && !last &&
               (cnt_q == 4'd0 || cnt_q == 4'd1));
    accept = s_valid && s_ready;
    ccff_shift_en = shift;
    ccff_head     = shift & sbuf_q[7];
    busy     = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    cfg_done = (state_q == ST_DONE);
`ifdef CCFF_CRC_CHECK_EN
    cfg_error = (state_q == ST_ERROR);
`else
    cfg_error = 1'b0;
`endif
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (go) state_d = ST_LOAD;
      end
      ST_LOAD: begin
`ifdef CCFF_CRC_CHECK_EN
        if (last) state_d = ST_CHECK;
`else
        if (last) state_d = ST_DONE;
`endif
      end
      ST_CHECK: begin
`ifdef CCFF_CRC_CHECK_EN
        if (accept && hi_vld_q)
          state_d = ({hi_q, s_data} == crc) ?
                    ST_DONE : ST_ERROR;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // byte buffer and bit counter; bits past the chain end are dropped
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      sbuf_q <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
    end else if (go) begin
      sbuf_q <= '0;
      cnt_q  <= '0;
      bit_q  <= '0;
    end else if (shift) begin
      bit_q <= bit_q + CW'(1);
      if (last) begin
        cnt_q <= '0;
      end else if (accept) begin
        sbuf_q <= s_data;
        cnt_q  <= 4'd8;
      end else begin
        sbuf_q <= {sbuf_q[6:0], 1'b0};
        cnt_q  <= cnt_q - 4'd1;
      end
    end else if (accept && state_q == ST_LOAD) begin
      sbuf_q <= s_data;
      cnt_q  <= 4'd8;
    end
  end

`ifdef CCFF_CRC_CHECK_EN
  // first received CRC byte, held until the second arrives
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      hi_q     <= '0;
      hi_vld_q <= 1'b0;
    end else if (go) begin
      hi_vld_q <= 1'b0;
    end else if (state_q == ST_CHECK && accept) begin
      hi_q     <= s_data;
      hi_vld_q <= 1'b1;
    end
  end

  ccff_crc16 u_crc (
    .clk   (prog_clk),
    .rst_n (prog_reset),
    .clr   (go),
    .en    (shift),
    .din   (ccff_head),
    .crc   (crc)
  );
`endif

endmodule

// File: doc/ccff_chain_loader.md
CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 64, number of configuration bits in the downstream ccff chain (legal range 1..65535).
REQ-002 SHALL have port prog_clk, input, 1, the single clock for all state; ccff chain is clocked by the same clock.
REQ-003 SHALL have port prog_reset, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1, single-cycle request to begin a load.
REQ-005 SHALL have port s_data, input, 8, bitstream byte, sent MSB first.
REQ-006 SHALL have port s_valid, input, 1, s_data valid.
REQ-007 SHALL have port s_ready, output, 1, loader accepts s_data this cycle.
REQ-008 SHALL have port ccff_head, output, 1, serial bit to the first tile's ccff_head.
REQ-009 SHALL have port ccff_shift_en, output, 1, chain shift enable; high exactly on cycles where ccff_head carries a valid bit.
REQ-010 SHALL have port cfg_done, output, 1, configuration complete, broadcast to tiles' cfg_done.
REQ-011 SHALL have port cfg_error, output, 1, load failed (CRC mismatch).
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE, DONE or ERROR.

Function
REQ-013 SHALL implement states IDLE, LOAD, CHECK, DONE and ERROR.
REQ-014 SHALL leave IDLE, DONE or ERROR for LOAD on start=1, clearing cfg_done, cfg_error, bit counter and byte buffer; start in LOAD or CHECK SHALL be ignored.
REQ-015 SHALL accept a byte on s_valid&&s_ready; s_ready is high in LOAD and CHECK only when the byte buffer is empty or its last bit is shifting out this cycle, so back-to-back bytes give one bit per cycle with no bubble.
REQ-016 SHALL present buffer bit 7 on ccff_head with ccff_shift_en=1 one cycle after acceptance, and shift one bit per cycle thereafter.
REQ-017 SHALL hold ccff_shift_en=0 and ccff_head=0 whenever the buffer is empty (underflow stall); the chain SHALL not shift during stalls.
REQ-018 SHALL count shifted bits; after bit CHAIN_LEN is shifted, remaining bits of the final byte SHALL be discarded (never shifted) and ccff_shift_en SHALL drop the next cycle.
REQ-019 Without CRC: after the last bit, SHALL enter DONE and assert cfg_done one cycle later; cfg_done SHALL hold until the next start or reset.
REQ-020 SHALL keep ccff_shift_en=0 in DONE, ERROR, IDLE and CHECK.
REQ-021 Bit counter width SHALL be $clog2(CHAIN_LEN+1); no wrap-around permitted.

Reset
REQ-022 On prog_reset=0, SHALL asynchronously force IDLE, s_ready=0, ccff_head=0, ccff_shift_en=0, cfg_done=0, cfg_error=0, busy=0, counters and CRC cleared.
REQ-023 Reset mid-LOAD SHALL abandon the load; partial chain contents are undefined and a new start is required.

Configuration
REQ-024 SHALL compile CRC checking in only when macro CCFF_CRC_CHECK_EN is defined.
REQ-025 With CCFF_CRC_CHECK_EN: SHALL run CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over exactly the CHAIN_LEN shifted bits, then in CHECK accept two further bytes (CRC MSB byte first) not shifted into the chain, and enter DONE on match or ERROR (cfg_error=1, cfg_done=0) on mismatch, one cycle after the second byte.
REQ-026 Without CCFF_CRC_CHECK_EN: the CHECK state SHALL be unreachable and cfg_error SHALL tie to 0.

Structure
REQ-027 Shared package ccff_loader_pkg SHALL hold the state enum, CRC16_POLY and CRC16_INIT constants.
REQ-028 CRC SHALL be a sub-module ccff_crc16 (1 bit/cycle, enable and clear inputs), instantiated only under CCFF_CRC_CHECK_EN.

Verification
REQ-029 CHAIN_LEN=8, start, byte 0xA5 streamed -> ccff_head sequence 1,0,1,0,0,1,0,1 on 8 consecutive shift_en cycles; cfg_done=1 one cycle after the last.
REQ-030 CHAIN_LEN=12, bytes 0xF0,0x3C with a 3-cycle s_valid gap -> 12 bits 1111_0000_0011 shifted, shift_en low for the gap cycles, low nibble 0xC never shifted.
REQ-031 CHAIN_LEN=64, 8 back-to-back bytes -> shift_en high for 64 contiguous cycles, s_ready never stalls the stream.
REQ-032 Reset asserted after 5 of 8 bits -> all outputs 0 immediately (asynchronously); a subsequent start with 0x5A loads 0,1,0,1,1,0,1,0 correctly.
REQ-033 CCFF_CRC_CHECK_EN, CHAIN_LEN=8, 0xA5 followed by golden-model CRC -> cfg_done=1, cfg_error=0; same with one CRC bit flipped -> cfg_error=1, cfg_done=0.
REQ-034 start pulsed during LOAD -> ignored; bit count and ccff_head sequence unchanged.
